mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between an instruction
// fetch port and a data port; stores into the program region below DATA_BASE are rejected.
module mem_arbiter #(
  parameter int          WIDTH       = 32,
  parameter int          MEM_LATENCY = 1,
  parameter logic [31:0] DATA_BASE   = 32'h1000_0000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_req_i,
  input  logic [WIDTH-1:0] if_addr_i,
  output logic             if_gnt_o,
  output logic             if_rvalid_o,
  output logic [WIDTH-1:0] if_rdata_o,
  input  logic             d_req_i,
  input  logic             d_we_i,
  input  logic [WIDTH-1:0] d_addr_i,
  input  logic [WIDTH-1:0] d_wdata_i,
  output logic             d_gnt_o,
  output logic             d_rvalid_o,
  output logic [WIDTH-1:0] d_rdata_o,
  output logic             d_err_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0]       CNT_LOAD = 4'(MEM_LATENCY - 1);
  localparam logic [WIDTH-1:0] BASE     = WIDTH'(DATA_BASE);

  function automatic logic in_data_region(input logic [WIDTH-1:0] addr);
    return (addr >= BASE);
  endfunction

  state_t           state_r;
  logic [3:0]       cnt_r;
  logic             last_data_r;
  logic             owner_data_r;
  logic             write_r;
  logic             err_pend_r;
  logic             mem_we_r;
  logic [WIDTH-1:0] mem_addr_r;
  logic [WIDTH-1:0] mem_wdata_r;
  logic             if_rvalid_r;
  logic             d_rvalid_r;
  logic             d_err_r;
  logic             busy_r;
  logic [WIDTH-1:0] if_rdata_r;
  logic [WIDTH-1:0] d_rdata_r;

  logic grant_if_s;
  logic grant_d_s;
  logic store_s;
  logic store_ok_s;

  // Arbitration: a lone requester wins, a conflict goes to the port not granted last.
  always_comb begin
    grant_if_s = 1'b0;
    grant_d_s  = 1'b0;
    if (reset && (state_r == ST_IDLE)) begin
      if (if_req_i && d_req_i) begin
        grant_if_s = last_data_r;
        grant_d_s  = ~last_data_r;
      end else begin
        grant_if_s = if_req_i;
        grant_d_s  = d_req_i;
      end
    end else begin
      grant_if_s = 1'b0;
      grant_d_s  = 1'b0;
    end
    store_s    = grant_d_s & d_we_i;
    store_ok_s = store_s & in_data_region(d_addr_i);
  end

  // Transaction sequencer: accept, wait out the memory latency, then respond once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      last_data_r  <= 1'b1;
      owner_data_r <= 1'b0;
      write_r      <= 1'b0;
      err_pend_r   <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {WIDTH{1'b0}};
      mem_wdata_r  <= {WIDTH{1'b0}};
      if_rvalid_r  <= 1'b0;
      d_rvalid_r   <= 1'b0;
      d_err_r      <= 1'b0;
      busy_r       <= 1'b0;
      if_rdata_r   <= {WIDTH{1'b0}};
      d_rdata_r    <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_if_s || grant_d_s) begin
            state_r      <= ST_WAIT;
            busy_r       <= 1'b1;
            cnt_r        <= CNT_LOAD;
            last_data_r  <= grant_d_s;
            owner_data_r <= grant_d_s;
            write_r      <= store_s;
            err_pend_r   <= store_s & ~store_ok_s;
            mem_we_r     <= store_ok_s;
            mem_addr_r   <= grant_d_s ? d_addr_i : if_addr_i;
            mem_wdata_r  <= grant_d_s ? d_wdata_i : {WIDTH{1'b0}};
          end
        end
        ST_WAIT: begin
          // Write strobe lasts only for the first WAIT cycle.
          mem_we_r <= 1'b0;
          if (cnt_r == 4'd0) begin
            state_r     <= ST_DONE;
            mem_addr_r  <= {WIDTH{1'b0}};
            mem_wdata_r <= {WIDTH{1'b0}};
            if (owner_data_r) begin
              d_rvalid_r <= 1'b1;
              d_err_r    <= err_pend_r;
              d_rdata_r  <= write_r ? {WIDTH{1'b0}} : mem_rdata_i;
            end else begin
              if_rvalid_r <= 1'b1;
              if_rdata_r  <= mem_rdata_i;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          if_rvalid_r <= 1'b0;
          d_rvalid_r  <= 1'b0;
          d_err_r     <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          mem_we_r    <= 1'b0;
          mem_addr_r  <= {WIDTH{1'b0}};
          mem_wdata_r <= {WIDTH{1'b0}};
          if_rvalid_r <= 1'b0;
          d_rvalid_r  <= 1'b0;
          d_err_r     <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt_o    = grant_if_s;
  assign d_gnt_o     = grant_d_s;
  assign if_rvalid_o = if_rvalid_r;
  assign if_rdata_o  = if_rdata_r;
  assign d_rvalid_o  = d_rvalid_r;
  assign d_rdata_o   = d_rdata_r;
  assign d_err_o     = d_err_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (MEM_LATENCY=2): a cycle-offset transaction
// model checked every cycle, plus directed vectors with hand-computed values.
module tb_mem_arbiter;
  localparam int          L    = 2;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clock;
  logic        reset;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        d_err_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.WIDTH(32), .MEM_LATENCY(L), .DATA_BASE(BASE)) dut (
    .clock(clock), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: k counts cycles since the accept; WAIT is k=1..L, DONE is k=L+1.
  logic        m_active, m_owner_d, m_wr, m_ok, m_err, m_last_d;
  int          m_k;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
  logic        e_if_gnt, e_d_gnt, e_we, e_if_rv, e_d_rv, e_err;
  logic [31:0] e_addr, e_wdata;

  initial begin
    m_active = 1'b0; m_k = 0; m_last_d = 1'b1; m_owner_d = 1'b0;
    m_wr = 1'b0; m_ok = 1'b0; m_err = 1'b0;
    m_addr = 32'd0; m_wdata = 32'd0; m_if_rdata = 32'd0; m_d_rdata = 32'd0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        m_active = 1'b0; m_k = 0; m_last_d = 1'b1;
        m_if_rdata = 32'd0; m_d_rdata = 32'd0;
        e_if_gnt = 1'b0; e_d_gnt = 1'b0; e_we = 1'b0;
        e_if_rv = 1'b0; e_d_rv = 1'b0; e_err = 1'b0;
        e_addr = 32'd0; e_wdata = 32'd0;
      end else begin
        e_if_gnt = !m_active && if_req_i && (!d_req_i || m_last_d);
        e_d_gnt  = !m_active && d_req_i && (!if_req_i || !m_last_d);
        e_we     = m_active && (m_k == 1) && m_ok;
        e_addr   = (m_active && m_k <= L) ? m_addr : 32'd0;
        e_wdata  = (m_active && m_k <= L) ? m_wdata : 32'd0;
        e_if_rv  = m_active && (m_k == L + 1) && !m_owner_d;
        e_d_rv   = m_active && (m_k == L + 1) && m_owner_d;
        e_err    = e_d_rv && m_err;
      end
      chk("m_if_gnt", 32'(if_gnt_o), 32'(e_if_gnt));
      chk("m_d_gnt", 32'(d_gnt_o), 32'(e_d_gnt));
      chk("m_busy", 32'(busy_o), 32'(reset && m_active));
      chk("m_mem_we", 32'(mem_we_o), 32'(e_we));
      chk("m_mem_addr", mem_addr_o, e_addr);
      chk("m_mem_wdata", mem_wdata_o, e_wdata);
      chk("m_if_rvalid", 32'(if_rvalid_o), 32'(e_if_rv));
      chk("m_d_rvalid", 32'(d_rvalid_o), 32'(e_d_rv));
      chk("m_d_err", 32'(d_err_o), 32'(e_err));
      chk("m_if_rdata", if_rdata_o, m_if_rdata);
      chk("m_d_rdata", d_rdata_o, m_d_rdata);
      if (reset) begin
        if (m_active) begin
          if (m_k == L) begin
            if (m_owner_d) m_d_rdata = m_wr ? 32'd0 : mem_rdata_i;
            else           m_if_rdata = mem_rdata_i;
          end
          if (m_k == L + 1) m_active = 1'b0;
          else              m_k = m_k + 1;
        end else if (e_if_gnt || e_d_gnt) begin
          m_active  = 1'b1;
          m_k       = 1;
          m_owner_d = e_d_gnt;
          m_last_d  = e_d_gnt;
          m_wr      = e_d_gnt && d_we_i;
          m_addr    = e_d_gnt ? d_addr_i : if_addr_i;
          m_wdata   = e_d_gnt ? d_wdata_i : 32'd0;
          m_ok      = m_wr && (d_addr_i >= BASE);
          m_err     = m_wr && (d_addr_i < BASE);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; if_req_i = 1'b0; if_addr_i = 32'd0; d_req_i = 1'b0; d_we_i = 1'b0;
    d_addr_i = 32'd0; d_wdata_i = 32'd0; mem_rdata_i = 32'd0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    @(posedge clock); #2 reset = 1'b1;

    // Continuous conflict: grants alternate fetch, data, fetch, data every 4 cycles.
    d_addr_i = 32'h1000_0040; d_wdata_i = 32'h1111_1111; d_we_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clock); #1;
      if_req_i = 1'b1; d_req_i = 1'b1; mem_rdata_i = 32'hC0DE_0000 | 32'(i);
      @(negedge clock);
      chk("rr_if_gnt", 32'(if_gnt_o), 32'(i % 8 == 0));
      chk("rr_d_gnt", 32'(d_gnt_o), 32'(i % 8 == 4));
      chk("rr_if_rvalid", 32'(if_rvalid_o), 32'(i % 8 == 3));
      chk("rr_d_rvalid", 32'(d_rvalid_o), 32'(i % 8 == 7));
      if (i % 8 == 3) chk("rr_if_rdata", if_rdata_o, 32'hC0DE_0000 | 32'(i - 1));
      if (i % 8 == 7) chk("rr_d_rdata", d_rdata_o, 32'hC0DE_0000 | 32'(i - 1));
    end
    @(posedge clock); #1; if_req_i = 1'b0; d_req_i = 1'b0;

    // Fetch-only, with a stray d_we_i that must not turn it into a write.
    @(posedge clock); #1;
    if_req_i = 1'b1; if_addr_i = 32'h0040_0000; mem_rdata_i = 32'h0050_0093;
    d_we_i = 1'b1; d_addr_i = 32'h1001_0000;
    @(negedge clock);
    chk("f_gnt", 32'(if_gnt_o), 32'd1);
    @(posedge clock); #1; if_req_i = 1'b0;
    @(negedge clock);
    chk("f_mem_addr", mem_addr_o, 32'h0040_0000);
    chk("f_mem_we", 32'(mem_we_o), 32'd0);
    @(negedge clock);
    @(negedge clock);
    chk("f_rvalid", 32'(if_rvalid_o), 32'd1);
    chk("f_rdata", if_rdata_o, 32'h0050_0093);

    // Store to data region; a fetch request raised while busy is withdrawn.
    @(posedge clock); #1;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h1001_0000; d_wdata_i = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("st_gnt", 32'(d_gnt_o), 32'd1);
    @(posedge clock); #1; d_req_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h0000_1000;
    @(negedge clock);
    chk("st_we", 32'(mem_we_o), 32'd1);
    chk("st_addr", mem_addr_o, 32'h1001_0000);
    chk("st_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("st_no_if_gnt", 32'(if_gnt_o), 32'd0);
    @(posedge clock); #1; if_req_i = 1'b0;
    @(negedge clock);
    chk("st_we_once", 32'(mem_we_o), 32'd0);
    @(negedge clock);
    chk("st_rvalid", 32'(d_rvalid_o), 32'd1);
    chk("st_err", 32'(d_err_o), 32'd0);
    chk("st_rdata", d_rdata_o, 32'd0);

    // Store into the read-only program region.
    @(posedge clock); #1;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0040_0010; d_wdata_i = 32'h1234_5678;
    @(negedge clock);
    chk("ro_gnt", 32'(d_gnt_o), 32'd1);
    @(posedge clock); #1; d_req_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clock);
      else       @(negedge clock);
      chk("ro_no_we", 32'(mem_we_o), 32'd0);
    end
    chk("ro_rvalid", 32'(d_rvalid_o), 32'd1);
    chk("ro_err", 32'(d_err_o), 32'd1);

    // Reset in cycle 2 of a load aborts it.
    @(posedge clock); #1;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h1000_0100; mem_rdata_i = 32'hCAFE_F00D;
    @(negedge clock);
    chk("rl_gnt", 32'(d_gnt_o), 32'd1);
    @(posedge clock); #1; d_req_i = 1'b0;
    @(posedge clock); #2 reset = 1'b0;
    #1;
    chk("rl_busy", 32'(busy_o), 32'd0);
    chk("rl_mem_addr", mem_addr_o, 32'd0);
    chk("rl_if_rdata", if_rdata_o, 32'd0);
    @(negedge clock);
    @(negedge clock);
    chk("rl_no_rvalid", 32'(d_rvalid_o), 32'd0);
    @(posedge clock); #2 reset = 1'b1;
    @(posedge clock); #1;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0200; mem_rdata_i = 32'h0000_0013;
    @(negedge clock);
    chk("rl_next_gnt", 32'(if_gnt_o), 32'd1);
    @(posedge clock); #1; if_req_i = 1'b0;
    repeat (3) @(negedge clock);
    chk("rl_next_rvalid", 32'(if_rvalid_o), 32'd1);
    chk("rl_next_rdata", if_rdata_o, 32'h0000_0013);

    // Reset while the write strobe is high drops it at once.
    @(posedge clock); #1;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h1002_0000; d_wdata_i = 32'hA5A5_5A5A;
    @(negedge clock);
    @(posedge clock); #1; d_req_i = 1'b0;
    chk("rs_we_pre", 32'(mem_we_o), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rs_we_drop", 32'(mem_we_o), 32'd0);
    chk("rs_mem_wdata", mem_wdata_o, 32'd0);
    @(negedge clock);
    @(posedge clock); #2 reset = 1'b1;

    // First conflict after reset goes to fetch again.
    @(posedge clock); #1; if_req_i = 1'b1; d_req_i = 1'b1; d_we_i = 1'b0;
    @(negedge clock);
    chk("rr2_if_gnt", 32'(if_gnt_o), 32'd1);
    chk("rr2_d_gnt", 32'(d_gnt_o), 32'd0);
    @(posedge clock); #1; if_req_i = 1'b0; d_req_i = 1'b0;
    repeat (5) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
